// File: rtl/spi_master_tx_pkg.sv
// Shared definitions for the SPI mode-3 transmit master: FSM states, bus constants
// and the helper that turns a cycle count into a timer load value.
package spi_master_tx_pkg;

    localparam int BYTE_W   = 8;
    localparam int TMR_W    = 16;
    localparam bit SPI_CPOL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOW,
        ST_HIGH,
        ST_WAIT,
        ST_HOLD,
        ST_GAP
    } state_e;

    // The timer counts down to zero inclusive, so N cycles of dwell load N-1.
    function automatic logic [TMR_W-1:0] tmr_len(input int cycles);
        return TMR_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/spi_master_tx_if.sv
// Byte stream between a producer and the SPI transmit master, plus the received-byte strobe.
interface spi_master_tx_if;
    import spi_master_tx_pkg::*;

    logic [BYTE_W-1:0] i_tx_data;
    logic              i_tx_valid;
    logic              i_tx_last;
    logic              o_tx_ready;
    logic [BYTE_W-1:0] o_rx_data;
    logic              o_rx_valid;

    modport master (
        output i_tx_data, i_tx_valid, i_tx_last,
        input  o_tx_ready, o_rx_data, o_rx_valid
    );

    modport slave (
        input  i_tx_data, i_tx_valid, i_tx_last,
        output o_tx_ready, o_rx_data, o_rx_valid
    );

endinterface

// File: rtl/spi_master_tx_timer.sv
// Loadable down-counter; o_done is high while the count sits at zero.
module spi_master_tx_timer
    import spi_master_tx_pkg::*;
(
    input  logic             i_clk50m,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [TMR_W-1:0] i_load_val,
    output logic             o_done
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TMR_W'(1);
        end
    end

    always_ff @(posedge i_clk50m) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_done = (cnt_q == '0);

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-3 master: frames bytes from a valid/ready stream into CS-delimited transactions
// (MSB first) and captures miso into a full-duplex readback byte.
module spi_master_tx
    import spi_master_tx_pkg::*;
#(
    parameter int HALF_CYCLES = 5,
    parameter int CS_SETUP    = 5,
    parameter int CS_HOLD     = 5,
    parameter int CS_GAP      = 10
) (
    input  logic           i_clk50m,
    input  logic           i_rst_n,
    spi_master_tx_if.slave bus,
    output logic           o_busy,
    output logic           o_sclk,
    output logic           o_cs,
    output logic           o_mosi,
    input  logic           i_miso
);

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] tx_q, tx_d;
    logic [BYTE_W-1:0] rx_q, rx_d;
    logic [2:0]        bit_q, bit_d;
    logic              last_q, last_d;
    logic              sclk_q, sclk_d;
    logic              cs_q, cs_d;
    logic              mosi_q, mosi_d;
    logic              ready_q, ready_d;
    logic              rx_valid_q, rx_valid_d;
    logic [BYTE_W-1:0] rx_data_q, rx_data_d;
    logic              busy_q, busy_d;

    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_done;
    logic              accept;
    logic              enter_low;
    logic [BYTE_W-1:0] low_src;

    spi_master_tx_timer u_timer (
        .i_clk50m   (i_clk50m),
        .i_rst_n    (i_rst_n),
        .i_load     (tmr_load),
        .i_load_val (tmr_val),
        .o_done     (tmr_done)
    );

    assign accept = bus.i_tx_valid & ready_q;

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        bit_d      = bit_q;
        last_d     = last_q;
        sclk_d     = sclk_q;
        cs_d       = cs_q;
        mosi_d     = mosi_q;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        busy_d     = busy_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        enter_low  = 1'b0;
        low_src    = tx_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    tx_d     = bus.i_tx_data;
                    last_d   = bus.i_tx_last;
                    cs_d     = 1'b0;
                    busy_d   = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = tmr_len(CS_SETUP);
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                enter_low = tmr_done;
            end
            ST_LOW: begin
                if (tmr_done) begin
                    sclk_d   = 1'b1;
                    rx_d     = {rx_q[BYTE_W-2:0], i_miso};
                    tmr_load = 1'b1;
                    tmr_val  = tmr_len(HALF_CYCLES);
                    state_d  = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (tmr_done) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q != 3'd7) begin
                        enter_low = 1'b1;
                    end else begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_q;
                        if (last_q) begin
                            tmr_load = 1'b1;
                            tmr_val  = tmr_len(CS_HOLD);
                            state_d  = ST_HOLD;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end
            end
            ST_WAIT: begin
                // Next byte of the same frame starts straight away, without another setup.
                if (accept) begin
                    last_d    = bus.i_tx_last;
                    low_src   = bus.i_tx_data;
                    enter_low = 1'b1;
                end
            end
            ST_HOLD: begin
                if (tmr_done) begin
                    cs_d     = 1'b1;
                    mosi_d   = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = tmr_len(CS_GAP);
                    state_d  = ST_GAP;
                end
            end
            ST_GAP: begin
                if (tmr_done) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (enter_low) begin
            sclk_d   = 1'b0;
            mosi_d   = low_src[BYTE_W-1];
            tx_d     = {low_src[BYTE_W-2:0], 1'b0};
            tmr_load = 1'b1;
            tmr_val  = tmr_len(HALF_CYCLES);
            state_d  = ST_LOW;
        end

        // Ready is registered, so it is derived from where the FSM lands next.
        ready_d = (state_d == ST_IDLE) || (state_d == ST_WAIT);
    end

    always_ff @(posedge i_clk50m) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            tx_q       <= '0;
            rx_q       <= '0;
            bit_q      <= '0;
            last_q     <= 1'b0;
            sclk_q     <= SPI_CPOL;
            cs_q       <= 1'b1;
            mosi_q     <= 1'b0;
            ready_q    <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            bit_q      <= bit_d;
            last_q     <= last_d;
            sclk_q     <= sclk_d;
            cs_q       <= cs_d;
            mosi_q     <= mosi_d;
            ready_q    <= ready_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.o_tx_ready = ready_q;
    assign bus.o_rx_data  = rx_data_q;
    assign bus.o_rx_valid = rx_valid_q;
    assign o_busy         = busy_q;
    assign o_sclk         = sclk_q;
    assign o_cs           = cs_q;
    assign o_mosi         = mosi_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Self-checking bench for spi_master_tx: a pin-level monitor reconstructs bytes and timing,
// which are compared with table vectors, hand sequences and random transactions.
module tb_spi_master_tx;

    localparam int HALF  = 5;
    localparam int SETUP = 5;
    localparam int HOLD  = 5;
    localparam int GAP   = 10;

    localparam logic [1:0] M_ZERO = 2'd0;
    localparam logic [1:0] M_ONE  = 2'd1;
    localparam logic [1:0] M_LOOP = 2'd2;
    localparam logic [1:0] M_RAND = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk, cs, mosi, miso, busy;
    logic [1:0] miso_mode = M_ZERO;
    bit         rand_bit = 1'b0;

    spi_master_tx_if ifc();

    always #10 clk = ~clk;

    assign miso = (miso_mode == M_LOOP) ? mosi :
                  (miso_mode == M_ONE)  ? 1'b1 :
                  (miso_mode == M_ZERO) ? 1'b0 : rand_bit;

    spi_master_tx #(
        .HALF_CYCLES (HALF),
        .CS_SETUP    (SETUP),
        .CS_HOLD     (HOLD),
        .CS_GAP      (GAP)
    ) dut (
        .i_clk50m (clk),
        .i_rst_n  (rst_n),
        .bus      (ifc),
        .o_busy   (busy),
        .o_sclk   (sclk),
        .o_cs     (cs),
        .o_mosi   (mosi),
        .i_miso   (miso)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pin-level observer: what a real SPI slave would see, plus timing measurements.
    bit         mosi_bits[$];
    bit         miso_bits[$];
    logic [7:0] rx_bytes[$];
    int rise_cnt = 0, cs_fall_cnt = 0, viol = 0, per_bad = 0;
    int setup_meas = -1, gap_min = 1000000, bit_in_txn = 0;
    int t_cs_fall = 0, t_cs_rise = -1, t_last_rise = 0;
    bit fall_pending = 1'b0, prev_sclk = 1'b1, prev_cs = 1'b1, prev_rxv = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_cs && !cs) begin
                cs_fall_cnt++;
                t_cs_fall    = cyc;
                fall_pending = 1'b1;
                bit_in_txn   = 0;
                if (t_cs_rise >= 0 && cyc - t_cs_rise < gap_min) gap_min = cyc - t_cs_rise;
            end
            if (!prev_cs && cs) begin
                t_cs_rise = cyc;
                if (cyc - t_last_rise < HOLD) viol++;
            end
            if (prev_sclk && !sclk) begin
                if (fall_pending) begin
                    setup_meas   = cyc - t_cs_fall;
                    fall_pending = 1'b0;
                end
                rand_bit = 1'($urandom_range(0, 1));
            end
            if (!prev_sclk && sclk && !cs) begin
                mosi_bits.push_back(mosi);
                miso_bits.push_back(miso);
                if (bit_in_txn % 8 != 0 && cyc - t_last_rise != 2 * HALF) per_bad++;
                bit_in_txn++;
                rise_cnt++;
                t_last_rise = cyc;
            end
            if (!sclk && cs) viol++;
            if (ifc.o_rx_valid) begin
                rx_bytes.push_back(ifc.o_rx_data);
                if (prev_rxv) viol++;
            end
        end
        prev_sclk = sclk;
        prev_cs   = cs;
        prev_rxv  = ifc.o_rx_valid;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [7:0] get_byte(input bit q[$], input int s);
        logic [7:0] r = '0;
        for (int i = 0; i < 8; i++) r = {r[6:0], q[s+i]};
        return r;
    endfunction

    int s_mosi, s_rx, s_rise, s_csf, s_viol, s_per;

    task automatic snap();
        s_mosi = mosi_bits.size();
        s_rx   = rx_bytes.size();
        s_rise = rise_cnt;
        s_csf  = cs_fall_cnt;
        s_viol = viol;
        s_per  = per_bad;
    endtask

    // Called at a negedge; returns at a negedge after the byte was accepted.
    task automatic send_byte(input logic [7:0] d, input logic l);
        int t = 0;
        ifc.i_tx_data  = d;
        ifc.i_tx_last  = l;
        ifc.i_tx_valid = 1'b1;
        while (!ifc.o_tx_ready && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 4000) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: got ready=0 after %0d cycles expected ready=1", t);
        end
        @(negedge clk);
        ifc.i_tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk("busy_timeout", int'(busy), 0);
    endtask

    task automatic check_txn(input string tag, input int n, input logic [2:0][7:0] d,
                             input logic [2:0][7:0] rx, input bit rx_from_miso);
        logic [7:0] exp_rx;
        chk({tag, "_rises"}, rise_cnt - s_rise, 8 * n);
        chk({tag, "_csfall"}, cs_fall_cnt - s_csf, 1);
        chk({tag, "_rxcnt"}, rx_bytes.size() - s_rx, n);
        for (int k = 0; k < n; k++) begin
            if (s_mosi + 8 * k + 7 < mosi_bits.size()) begin
                chk({tag, "_mosi"}, int'(get_byte(mosi_bits, s_mosi + 8 * k)), int'(d[k]));
                exp_rx = rx_from_miso ? get_byte(miso_bits, s_mosi + 8 * k) : rx[k];
                if (s_rx + k < rx_bytes.size())
                    chk({tag, "_rxdata"}, int'(rx_bytes[s_rx+k]), int'(exp_rx));
            end
        end
        chk({tag, "_viol"}, viol - s_viol, 0);
        chk({tag, "_period"}, per_bad - s_per, 0);
        chk({tag, "_setup"}, setup_meas, SETUP);
    endtask

    typedef struct {
        int              n;
        logic [2:0][7:0] d;
        logic [1:0]      mode;
        logic [2:0][7:0] rx;
    } vec_t;

    function automatic vec_t mk(input int n, input logic [7:0] d0, input logic [7:0] d1,
                                input logic [7:0] d2, input logic [1:0] mode,
                                input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2);
        vec_t v;
        v.n = n;
        v.d = {d2, d1, d0};
        v.mode = mode;
        v.rx = {r2, r1, r0};
        return v;
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t            vt[6];
        logic [2:0][7:0] rd;
        int              t;
        int              bad;
        int              n;

        vt[0] = mk(1, 8'hB5, 8'h00, 8'h00, M_ZERO, 8'h00, 8'h00, 8'h00);
        vt[1] = mk(2, 8'hB5, 8'h10, 8'h00, M_ZERO, 8'h00, 8'h00, 8'h00);
        vt[2] = mk(1, 8'h3C, 8'h00, 8'h00, M_LOOP, 8'h3C, 8'h00, 8'h00);
        vt[3] = mk(2, 8'hFF, 8'h00, 8'h00, M_ONE,  8'hFF, 8'hFF, 8'h00);
        vt[4] = mk(3, 8'h81, 8'h7E, 8'hC6, M_LOOP, 8'h81, 8'h7E, 8'hC6);
        vt[5] = mk(1, 8'h00, 8'h00, 8'h00, M_ONE,  8'hFF, 8'h00, 8'h00);

        ifc.i_tx_data  = '0;
        ifc.i_tx_valid = 1'b0;
        ifc.i_tx_last  = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sclk", int'(sclk), 1);
        chk("rst_cs", int'(cs), 1);
        chk("rst_mosi", int'(mosi), 0);
        chk("rst_ready", int'(ifc.o_tx_ready), 0);
        chk("rst_rxvalid", int'(ifc.o_rx_valid), 0);
        chk("rst_rxdata", int'(ifc.o_rx_data), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", int'(ifc.o_tx_ready), 1);

        // Table vectors, sent back-to-back so the inter-transaction gap is exercised too.
        for (int i = 0; i < 6; i++) begin
            miso_mode = vt[i].mode;
            snap();
            for (int k = 0; k < vt[i].n; k++) send_byte(vt[i].d[k], k == vt[i].n - 1);
            wait_idle();
            check_txn("vec", vt[i].n, vt[i].d, vt[i].rx, 1'b0);
            $display("vec %0d: n=%0d d=%h rx=%h", i, vt[i].n, vt[i].d, vt[i].rx);
        end
        chk("gap_min_ok", int'(gap_min >= GAP), 1);

        // Stall between bytes: frame stays open with sclk parked high.
        miso_mode = M_LOOP;
        snap();
        send_byte(8'h5A, 1'b0);
        t = 0;
        while (rx_bytes.size() - s_rx < 1 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk("wait_first_rx", rx_bytes.size() - s_rx, 1);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (!(cs == 1'b0 && sclk == 1'b1 && ifc.o_tx_ready == 1'b1)) bad++;
        end
        chk("wait_state_hold", bad, 0);
        send_byte(8'hA5, 1'b1);
        wait_idle();
        rd = {8'h00, 8'hA5, 8'h5A};
        check_txn("stall", 2, rd, rd, 1'b0);
        $display("stall: 5A then A5 after 40-cycle hold");

        // Reset in the middle of a byte.
        miso_mode = M_ONE;
        snap();
        send_byte(8'hC3, 1'b1);
        t = 0;
        while (rise_cnt - s_rise < 3 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk("rst_mid_rises", rise_cnt - s_rise, 3);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rstmid_cs", int'(cs), 1);
        chk("rstmid_sclk", int'(sclk), 1);
        chk("rstmid_mosi", int'(mosi), 0);
        chk("rstmid_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("rstmid_no_rx", rx_bytes.size() - s_rx, 0);
        miso_mode = M_LOOP;
        snap();
        send_byte(8'h96, 1'b1);
        wait_idle();
        rd = {8'h00, 8'h00, 8'h96};
        check_txn("post_rst", 1, rd, rd, 1'b0);
        $display("reset mid-byte then clean send 96");

        // Random frames with random miso and random stalls between bytes.
        for (int r = 0; r < 15; r++) begin
            n = $urandom_range(1, 3);
            miso_mode = M_RAND;
            rd = '0;
            snap();
            for (int k = 0; k < n; k++) begin
                rd[k] = 8'($urandom);
                send_byte(rd[k], k == n - 1);
                if (k < n - 1) repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            wait_idle();
            check_txn("rnd", n, rd, '0, 1'b1);
            $display("rnd %0d: n=%0d d=%h", r, n, rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
